// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//
// Purpose:
//   Merges the core's instruction and data SRAM-like request channels into one
//   SRAM-like master channel for a single-port SRAM-to-AXI bridge. Address-phase
//   requests are arbitrated and a grant is held stable until the bridge accepts
//   it. An in-order owner FIFO remembers which channel issued each accepted
//   request so each returned data_ok/rdata goes back to the right channel.
//
// Configuration macro:
//   SRAM_ARB_RR_EN  defined   -> round-robin between channels on conflict
//                   undefined -> fixed priority, data over inst
//
// Parameters:
//   DEPTH  max outstanding accepted-but-unanswered requests (power of 2, 2..16)
//   PTR_W  FIFO pointer width, derived from DEPTH
//
// Ports:
//   clk, reset                        clock, async active-high reset
//   inst_sram_*  (req/wr/size/addr/wstrb/wdata in; addr_ok/data_ok/rdata out)
//   data_sram_*  (req/wr/size/addr/wstrb/wdata in; addr_ok/data_ok/rdata out)
//   mem_*        (req/wr/size/addr/wstrb/wdata out; addr_ok/data_ok/rdata in)

module sram_req_arbiter #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  // Owner encoding: 0 = inst, 1 = data
  logic [DEPTH-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             locked_q, locked_d;
  logic             lock_owner_q, lock_owner_d;

  logic full, empty, grant, push, pop, head_owner;

`ifdef SRAM_ARB_RR_EN
  // Preferred owner for the next conflict; flips away from each accepted owner.
  logic rr_q, rr_d;
`endif

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);

    // A stalled request keeps the grant so the bridge sees stable fields.
    if (locked_q) begin
      grant = lock_owner_q;
    end else if (inst_sram_req && data_sram_req) begin
`ifdef SRAM_ARB_RR_EN
      grant = rr_q;
`else
      grant = 1'b1;
`endif
    end else begin
      grant = data_sram_req;
    end

    mem_req   = (grant ? data_sram_req : inst_sram_req) && !full && !reset;
    mem_wr    = grant ? data_sram_wr    : inst_sram_wr;
    mem_size  = grant ? data_sram_size  : inst_sram_size;
    mem_addr  = grant ? data_sram_addr  : inst_sram_addr;
    mem_wstrb = grant ? data_sram_wstrb : inst_sram_wstrb;
    mem_wdata = grant ? data_sram_wdata : inst_sram_wdata;

    push = mem_req && mem_addr_ok;
    // Responses with nothing outstanding are dropped without touching the FIFO.
    pop  = mem_data_ok && !empty && !reset;
    head_owner = owner_q[rd_ptr_q];

    inst_sram_addr_ok = push && !grant;
    data_sram_addr_ok = push &&  grant;
    inst_sram_data_ok = pop && !head_owner;
    data_sram_data_ok = pop &&  head_owner;
    inst_sram_rdata   = mem_rdata;
    data_sram_rdata   = mem_rdata;

    // Lock holds exactly while a presented request is waiting; acceptance or
    // the owner dropping its request both release it.
    locked_d     = mem_req && !mem_addr_ok;
    lock_owner_d = locked_d ? grant : lock_owner_q;

    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      owner_d[wr_ptr_q] = grant;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

`ifdef SRAM_ARB_RR_EN
    rr_d = push ? !grant : rr_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter
//
// Purpose:
//   Self-checking bench for sram_req_arbiter. Directed scenarios drive both
//   request channels and the bridge handshakes; a queue-based reference model
//   predicts every output each cycle, and a set of literal expectations pins
//   the scenario results.
//
// Ports: none (top-level bench).

module tb_sram_req_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = 2'd2;
  logic [31:0] inst_sram_addr = '0;
  logic [3:0]  inst_sram_wstrb = 4'b0000;
  logic [31:0] inst_sram_wdata = '0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
  logic [1:0]  data_sram_size = 2'd1;
  logic [31:0] data_sram_addr = '0;
  logic [3:0]  data_sram_wstrb = 4'b0011;
  logic [31:0] data_sram_wdata = '0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  sram_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and returns at the
  // following falling edge, where outputs are stable for checking.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic aok, input logic dok, input logic [31:0] rd);
    @(posedge clk);
    #1;
    inst_sram_req   = ir;
    inst_sram_addr  = ia;
    inst_sram_wdata = ia ^ 32'h0000_ffff;
    data_sram_req   = dr;
    data_sram_wr    = dw;
    data_sram_addr  = da;
    data_sram_wdata = da ^ 32'h5a5a_5a5a;
    mem_addr_ok     = aok;
    mem_data_ok     = dok;
    mem_rdata       = rd;
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    data_sram_wr  = 1'b0;
    mem_addr_ok   = 1'b0;
    mem_data_ok   = 1'b0;
    @(negedge clk);
    checkOutput("rst_count", {29'd0, dut.count_q}, 32'd0);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: a queue of owners for outstanding requests, the owner of
  // a currently stalled request (-1 when none) and the round-robin preference.
  initial begin : model
    bit owners[$];
    int stall;
    bit pref, g, exp_req, push, pop, head;
    stall = -1;
    pref  = 1'b0;
    forever begin
      @(negedge clk);
      if (stall >= 0) begin
        g = stall[0];
      end else if (inst_sram_req && data_sram_req) begin
`ifdef SRAM_ARB_RR_EN
        g = pref;
`else
        g = 1'b1;
`endif
      end else begin
        g = data_sram_req;
      end
      exp_req = !reset && (g ? data_sram_req : inst_sram_req) && (owners.size() < DEPTH);
      push    = exp_req && mem_addr_ok;
      pop     = !reset && mem_data_ok && (owners.size() > 0);
      head    = (owners.size() > 0) ? owners[0] : 1'b0;

      checkOutput("mem_req", mem_req, exp_req);
      checkOutput("inst_addr_ok", inst_sram_addr_ok, push && !g);
      checkOutput("data_addr_ok", data_sram_addr_ok, push && g);
      checkOutput("inst_data_ok", inst_sram_data_ok, pop && !head);
      checkOutput("data_data_ok", data_sram_data_ok, pop && head);
      checkOutput("inst_rdata", inst_sram_rdata, mem_rdata);
      checkOutput("data_rdata", data_sram_rdata, mem_rdata);
      if (exp_req) begin
        checkOutput("mem_addr", mem_addr, g ? data_sram_addr : inst_sram_addr);
        checkOutput("mem_wdata", mem_wdata, g ? data_sram_wdata : inst_sram_wdata);
        checkOutput("mem_ctrl", {25'd0, mem_wr, mem_size, mem_wstrb},
                    g ? {25'd0, data_sram_wr, data_sram_size, data_sram_wstrb}
                      : {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb});
      end
      if (!reset) begin
        checkOutput("count", {29'd0, dut.count_q}, owners.size());
      end

      @(posedge clk);
      if (reset) begin
        owners.delete();
        stall = -1;
        pref  = 1'b0;
      end else begin
        if (pop) void'(owners.pop_front());
        if (push) begin
          owners.push_back(g);
          pref = !g;
        end
        stall = (exp_req && !mem_addr_ok) ? int'(g) : -1;
      end
    end
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("init_count", {29'd0, dut.count_q}, 32'd0);
    checkOutput("init_mem_req", mem_req, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] inst only");
    applyStimulus(1, 32'h1c00_0000, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_addr", mem_addr, 32'h1c00_0000);
    checkOutput("t1_aok_wait", inst_sram_addr_ok, 1'b0);
    applyStimulus(1, 32'h1c00_0000, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_aok", inst_sram_addr_ok, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0280_0c00);
    checkOutput("t1_dok", inst_sram_data_ok, 1'b1);
    checkOutput("t1_rdata", inst_sram_rdata, 32'h0280_0c00);
    checkOutput("t1_data_dok", data_sram_data_ok, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_dok_once", inst_sram_data_ok, 1'b0);

    $display("[TB] conflict");
    pulseReset();
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 1, 0, 0);
`ifdef SRAM_ARB_RR_EN
    checkOutput("t2_first_inst", inst_sram_addr_ok, 1'b1);
    checkOutput("t2_first_addr", mem_addr, 32'h100);
`else
    checkOutput("t2_first_data", data_sram_addr_ok, 1'b1);
    checkOutput("t2_first_addr", mem_addr, 32'h200);
`endif
    applyStimulus(1, 32'h100, 1, 0, 32'h204, 1, 0, 0);
    checkOutput("t2_second_data", data_sram_addr_ok, 1'b1);
    checkOutput("t2_second_addr", mem_addr, 32'h204);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h22);

    $display("[TB] lock");
    pulseReset();
    applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("t3_c0_addr", mem_addr, 32'h300);
    applyStimulus(1, 32'h400, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("t3_c1_addr", mem_addr, 32'h300);
    applyStimulus(1, 32'h400, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("t3_c2_addr", mem_addr, 32'h300);
    applyStimulus(1, 32'h400, 1, 0, 32'h300, 1, 0, 0);
    checkOutput("t3_data_aok", data_sram_addr_ok, 1'b1);
    checkOutput("t3_inst_wait", inst_sram_addr_ok, 1'b0);
    applyStimulus(1, 32'h400, 0, 0, 0, 1, 0, 0);
    checkOutput("t3_inst_aok", inst_sram_addr_ok, 1'b1);
    checkOutput("t3_inst_addr", mem_addr, 32'h400);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h33);
    checkOutput("t3_data_dok", data_sram_data_ok, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h44);
    checkOutput("t3_inst_dok", inst_sram_data_ok, 1'b1);

    $display("[TB] full");
    pulseReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 32'h10 + 32'(4 * i), 0, 0, 0, 1, 0, 0);
      checkOutput("t4_fill_aok", inst_sram_addr_ok, 1'b1);
    end
    applyStimulus(1, 32'h20, 0, 0, 0, 1, 0, 0);
    checkOutput("t4_full_req", mem_req, 1'b0);
    applyStimulus(1, 32'h20, 0, 0, 0, 1, 1, 32'h55);
    checkOutput("t4_pop_req", mem_req, 1'b0);
    checkOutput("t4_pop_aok", inst_sram_addr_ok, 1'b0);
    checkOutput("t4_pop_dok", inst_sram_data_ok, 1'b1);
    applyStimulus(1, 32'h20, 0, 0, 0, 1, 0, 0);
    checkOutput("t4_fifth_aok", inst_sram_addr_ok, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h60 + 32'(i));
    end

    $display("[TB] ordering");
    pulseReset();
    applyStimulus(1, 32'h40, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 32'h44, 1, 0, 0);
    checkOutput("t5_wr", mem_wr, 1'b1);
    checkOutput("t5_data_aok", data_sram_addr_ok, 1'b1);
    applyStimulus(1, 32'h48, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hA);
    checkOutput("t5_a_inst", inst_sram_data_ok, 1'b1);
    checkOutput("t5_a_data", data_sram_data_ok, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hB);
    checkOutput("t5_b_inst", inst_sram_data_ok, 1'b0);
    checkOutput("t5_b_data", data_sram_data_ok, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hC);
    checkOutput("t5_c_inst", inst_sram_data_ok, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hD);
    checkOutput("t5_d_inst", inst_sram_data_ok, 1'b0);
    checkOutput("t5_d_data", data_sram_data_ok, 1'b0);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 32'h50, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h54, 1, 0, 0);
    checkOutput("t6_count2", {29'd0, dut.count_q}, 32'd1);
    pulseReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h77);
    checkOutput("t6_inst_dok", inst_sram_data_ok, 1'b0);
    checkOutput("t6_data_dok", data_sram_data_ok, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
